mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 54 +++++
 rtl/mem_port_arbiter_lsu_load_align.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared types, encodings and lane helpers for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] MASK_BYTE = 2'b01;
    localparam logic [1:0] MASK_HALF = 2'b10;
    localparam logic [1:0] MASK_WORD = 2'b11;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Size 00 is handled as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] addr_lo);
        case (mask)
            MASK_BYTE: return 1'b0;
            MASK_HALF: return addr_lo[0];
            default:   return (addr_lo != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] mask, input logic [1:0] addr_lo);
        case (mask)
            MASK_BYTE: return 4'b0001 << addr_lo;
            MASK_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] place_wdata(input logic [1:0] mask, input logic [31:0] wdata);
        case (mask)
            MASK_BYTE: return {4{wdata[7:0]}};
            MASK_HALF: return {2{wdata[15:0]}};
            default:   return wdata;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Purpose  : Selects the addressed load lane and sign/zero-extends it.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   data = {{16{w_half[15]}}, w_half};
            F3_LBU:  data = {24'd0, w_byte};
            F3_LHU:  data = {16'd0, w_half};
            default: data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between fetch and data requesters,
//            data first, with alignment checks and a wait-cycle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_mask,
    input  logic [2:0]  d_funct3,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int                  c_CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_addr;
    logic               r_we;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [2:0]         r_funct3;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_resp_fetch;
    logic               r_err;
    logic [31:0]        r_if_rdata;
    logic [31:0]        r_d_rdata;
    logic               w_misalign;
    logic               w_timeout;
    logic               w_busy;
    logic [31:0]        w_load_data;

    assign w_misalign = is_misaligned(d_mask, d_addr[1:0]);
    assign w_busy     = (r_state == S_FETCH) || (r_state == S_DATA);
    // Fires on the last permitted wait cycle, so mem_req is up for exactly TIMEOUT_CYCLES cycles.
    assign w_timeout  = w_busy && !mem_ready && (r_wait_cnt == c_TIMEOUT_LAST);

    lsu_load_align u_load_align (
        .rdata  (mem_rdata),
        .addr   (r_addr[1:0]),
        .funct3 (r_funct3),
        .data   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (d_req) begin
                    w_state_next = w_misalign ? S_RESP : S_DATA;
                end else if (if_req) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH, S_DATA: begin
                if (mem_ready || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        if_valid = 1'b0;
        d_valid  = 1'b0;
        d_err    = 1'b0;
        case (r_state)
            S_FETCH, S_DATA: mem_req = 1'b1;
            S_RESP: begin
                if_valid = r_resp_fetch;
                d_valid  = !r_resp_fetch;
                d_err    = !r_resp_fetch && r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_funct3     <= '0;
            r_wait_cnt   <= '0;
            r_resp_fetch <= 1'b0;
            r_err        <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (d_req) begin
                        r_resp_fetch <= 1'b0;
                        if (w_misalign) begin
                            r_err     <= 1'b1;
                            r_d_rdata <= '0;
                        end else begin
                            r_err      <= 1'b0;
                            r_wait_cnt <= '0;
                            r_addr     <= d_addr;
                            r_we       <= d_we;
                            r_be       <= byte_enables(d_mask, d_addr[1:0]);
                            r_wdata    <= place_wdata(d_mask, d_wdata);
                            r_funct3   <= d_funct3;
                        end
                    end else if (if_req) begin
                        r_resp_fetch <= 1'b1;
                        r_err        <= 1'b0;
                        r_wait_cnt   <= '0;
                        r_addr       <= if_addr;
                        r_we         <= 1'b0;
                        r_be         <= 4'b1111;
                        r_wdata      <= '0;
                        r_funct3     <= F3_LW;
                    end
                end
                S_FETCH, S_DATA: begin
                    if (!mem_ready) begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
                    if (mem_ready) begin
                        if (r_state == S_FETCH) r_if_rdata <= mem_rdata;
                        else                    r_d_rdata  <= w_load_data;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (r_state == S_FETCH) r_if_rdata <= NOP_INSN;
                        else                    r_d_rdata  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_mask;
    logic [2:0]  d_funct3;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_checks = 0;
    int n_pass   = 0;
    int both_cnt = 0;

    logic [31:0] got_data;
    logic        got_err;
    logic        got_valid;
    int          n_wait;

    mem_port_arbiter #(.TIMEOUT_CYCLES(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_mask    (d_mask),
        .d_funct3  (d_funct3),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if_valid && d_valid) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dload(input logic [31:0] a, input logic [1:0] m, input logic [2:0] f3,
                         input logic [31:0] md);
        d_req = 1'b1; d_we = 1'b0; d_addr = a; d_mask = m; d_funct3 = f3;
        tick();
        mem_ready = 1'b1; mem_rdata = md;
        tick();
        got_data = d_rdata; got_err = d_err; got_valid = d_valid;
        d_req = 1'b0; mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_mask = 2'b11; d_funct3 = 3'd2;
        mem_rdata = '0; mem_ready = 1'b0;
        #3;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Fetch with single-cycle memory
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("fetch_req", {31'd0, mem_req}, 32'd1);
        chk("fetch_addr", mem_addr, 32'h100);
        chk("fetch_we_be", {27'd0, mem_we, mem_be}, 32'h0F);
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("fetch_valid", {30'd0, if_valid, d_valid}, 32'h2);
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
        chk("fetch_resp_noreq", {31'd0, mem_req}, 32'd0);
        if_req = 1'b0; mem_ready = 1'b0;
        tick();
        chk("fetch_valid_drop", {30'd0, if_valid, d_valid}, 32'd0);
        chk("fetch_rdata_hold", if_rdata, 32'hDEADBEEF);

        // Simultaneous requests: data wins
        if_req = 1'b1; if_addr = 32'h180;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_mask = 2'b11; d_funct3 = 3'd2;
        tick();
        chk("prio_addr", mem_addr, 32'h200);
        mem_ready = 1'b1; mem_rdata = 32'h11223344;
        tick();
        chk("prio_dvalid", {30'd0, if_valid, d_valid}, 32'h1);
        chk("prio_drdata", d_rdata, 32'h11223344);
        d_req = 1'b0; mem_ready = 1'b0;
        tick();
        chk("prio_idle_gap", {29'd0, mem_req, if_valid, d_valid}, 32'd0);
        tick();
        chk("prio_fetch_addr", mem_addr, 32'h180);
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        chk("prio_ivalid", {30'd0, if_valid, d_valid}, 32'h2);
        chk("prio_irdata", if_rdata, 32'hCAFEF00D);
        if_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Load lane select and extension
        dload(32'h203, 2'b01, 3'd0, 32'h80123456);
        chk("lb_neg", got_data, 32'hFFFFFF80);
        chk("lb_valid", {30'd0, got_valid, got_err}, 32'h2);
        dload(32'h203, 2'b01, 3'd4, 32'h80123456);
        chk("lbu", got_data, 32'h00000080);
        dload(32'h202, 2'b10, 3'd5, 32'h80015678);
        chk("lhu", got_data, 32'h00008001);
        dload(32'h200, 2'b10, 3'd1, 32'h1234F00D);
        chk("lh_neg", got_data, 32'hFFFFF00D);
        dload(32'h201, 2'b01, 3'd0, 32'h00007F00);
        chk("lb_pos_lane1", got_data, 32'h0000007F);
        dload(32'h204, 2'b00, 3'd7, 32'hA5A55A5A);
        chk("lw_default", got_data, 32'hA5A55A5A);

        // Store half with wait states: outputs must hold steady
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h302; d_mask = 2'b10; d_wdata = 32'h00001234;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("sh_addr", mem_addr, 32'h300);
            chk("sh_be_we_req", {26'd0, mem_req, mem_we, mem_be}, 32'h3C);
            chk("sh_wdata", mem_wdata, 32'h12341234);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        chk("sh_resp", {29'd0, mem_req, d_valid, d_err}, 32'h2);
        d_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Store byte
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h101; d_mask = 2'b01; d_wdata = 32'hFFFFFFAB;
        tick();
        chk("sb_be", {28'd0, mem_be}, 32'h2);
        chk("sb_wdata", mem_wdata, 32'hABABABAB);
        mem_ready = 1'b1;
        tick();
        d_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Misaligned accesses: immediate error, no memory request
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h401; d_mask = 2'b11; d_funct3 = 3'd2;
        tick();
        chk("mis_w_resp", {29'd0, mem_req, d_valid, d_err}, 32'h3);
        chk("mis_w_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        tick();
        chk("mis_w_clear", {29'd0, mem_req, d_valid, d_err}, 32'd0);
        d_req = 1'b1; d_addr = 32'h203; d_mask = 2'b10; d_funct3 = 3'd1;
        tick();
        chk("mis_h_resp", {29'd0, mem_req, d_valid, d_err}, 32'h3);
        d_req = 1'b0;
        tick();

        // Data timeout
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_mask = 2'b11; d_funct3 = 3'd2;
        tick();
        n_wait = 0;
        while (mem_req && n_wait < 400) begin
            n_wait++;
            tick();
        end
        chk("to_d_cycles", n_wait, 32'd255);
        chk("to_d_resp", {30'd0, d_valid, d_err}, 32'h3);
        d_req = 1'b0;
        tick();

        // Fetch timeout returns a NOP
        if_req = 1'b1; if_addr = 32'h600;
        tick();
        n_wait = 0;
        while (mem_req && n_wait < 400) begin
            n_wait++;
            tick();
        end
        chk("to_f_cycles", n_wait, 32'd255);
        chk("to_f_valid", {30'd0, if_valid, d_valid}, 32'h2);
        chk("to_f_nop", if_rdata, 32'h00000013);
        if_req = 1'b0;
        tick();

        // Asynchronous reset in the middle of a data access
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; d_mask = 2'b11; d_funct3 = 3'd2;
        tick();
        chk("arst_pre_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {30'd0, mem_req, d_valid}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_rdata", d_rdata | if_rdata, 32'd0);
        d_req = 1'b0;
        tick();
        chk("arst_no_dvalid", {31'd0, d_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        if_req = 1'b1; if_addr = 32'h800;
        tick();
        chk("post_rst_addr", mem_addr, 32'h800);
        mem_ready = 1'b1; mem_rdata = 32'h0BADCAFE;
        tick();
        chk("post_rst_valid", {30'd0, if_valid, d_valid}, 32'h2);
        chk("post_rst_rdata", if_rdata, 32'h0BADCAFE);
        if_req = 1'b0; mem_ready = 1'b0;
        tick();

        chk("never_both_valid", both_cnt, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
